// File: rtl/flex_word_sr_if.sv
// Bundle of the control, serial and word-handshake signals of flex_word_sr.
// The master drives shift/load/serial data and consumes words; the slave is the shift register.
interface flex_word_sr_if #(
  parameter int NUM_BITS = 8
);
  localparam int CW = $clog2(NUM_BITS);

  logic                shift_enable;
  logic                msb_first;
  logic                serial_in;
  logic                load_enable;
  logic [NUM_BITS-1:0] load_data;
  logic                serial_out;
  logic [NUM_BITS-1:0] parallel_out;
  logic [NUM_BITS-1:0] word_out;
  logic                word_valid;
  logic                word_ready;
  logic                overrun;
  logic [CW-1:0]       bit_count;

  modport master (
    output shift_enable, msb_first, serial_in, load_enable, load_data, word_ready,
    input  serial_out, parallel_out, word_out, word_valid, overrun, bit_count
  );

  modport slave (
    input  shift_enable, msb_first, serial_in, load_enable, load_data, word_ready,
    output serial_out, parallel_out, word_out, word_valid, overrun, bit_count
  );
endinterface

// File: rtl/flex_word_sr.sv
// Bidirectional shift register that assembles NUM_BITS-bit words and hands each
// completed word to a consumer through a one-entry holding register.
module flex_word_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit RESET_BIT = 1'b1
) (
  input logic           clk,
  input logic           rst,
  flex_word_sr_if.slave bus
);
  localparam int            CW   = $clog2(NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] sr_q;
  logic [NUM_BITS-1:0] sr_next;
  logic [CW-1:0]       cnt_q;
  logic [NUM_BITS-1:0] word_q;
  logic                valid_q;
  logic                overrun_q;
  logic                do_shift;
  logic                capture;
  logic                accept;
  logic                drop;

  // Word handshake: word_out is transferred on any cycle where word_valid and
  // word_ready are both 1; word_valid only falls after such a transfer, and a
  // new word may replace the transferred one in that same cycle.
  assign do_shift = bus.shift_enable & ~bus.load_enable;
  assign capture  = do_shift & (cnt_q == LAST);
  assign accept   = capture & (~valid_q | bus.word_ready);
  assign drop     = capture & valid_q & ~bus.word_ready;

  always_comb begin
    sr_next = sr_q;
    if (bus.msb_first) sr_next = {sr_q[NUM_BITS-2:0], bus.serial_in};
    else               sr_next = {bus.serial_in, sr_q[NUM_BITS-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= {NUM_BITS{RESET_BIT}};
      cnt_q <= '0;
    end else if (bus.load_enable) begin
      sr_q  <= bus.load_data;
      cnt_q <= '0;
    end else if (do_shift) begin
      sr_q  <= sr_next;
      cnt_q <= capture ? '0 : cnt_q + 1'b1;
    end
  end

  // Holding register: a captured word carries the post-shift contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        word_q  <= sr_next;
        valid_q <= 1'b1;
      end else if (valid_q && bus.word_ready) begin
        valid_q <= 1'b0;
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign bus.serial_out   = bus.msb_first ? sr_q[NUM_BITS-1] : sr_q[0];
  assign bus.parallel_out = sr_q;
  assign bus.word_out     = word_q;
  assign bus.word_valid   = valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.bit_count    = cnt_q;
endmodule

// File: tb/tb_flex_word_sr.sv
// Directed and randomized checks of flex_word_sr (NUM_BITS=8, RESET_BIT=1)
// against a bit-level reference model with a word scoreboard.
module tb_flex_word_sr;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  flex_word_sr_if #(.NUM_BITS(8)) bus ();

  flex_word_sr #(.NUM_BITS(8), .RESET_BIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_sr;
  int         m_cnt;
  logic [7:0] m_word;
  logic       m_overrun;
  logic [7:0] exp_q[$];

  task automatic model_reset();
    m_sr      = 8'hFF;
    m_cnt     = 0;
    m_word    = 8'h00;
    m_overrun = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic ld, input logic sh, input logic msb,
                            input logic sin, input logic [7:0] ldata, input logic rdy);
    logic cap;
    cap = 1'b0;
    if (ld) begin
      m_sr  = ldata;
      m_cnt = 0;
    end else if (sh) begin
      if (msb) m_sr = 8'((m_sr << 1) | {7'b0, sin});
      else     m_sr = 8'((m_sr >> 1) | ({7'b0, sin} << 7));
      m_cnt = m_cnt + 1;
      if (m_cnt == 8) begin
        m_cnt = 0;
        cap   = 1'b1;
      end
    end
    if (cap) begin
      if (exp_q.size() == 0 || rdy) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(m_sr);
        m_word = m_sr;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (rdy && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic sout;
    sout = bus.msb_first ? m_sr[7] : m_sr[0];
    chk({tag, ".parallel_out"}, 64'(bus.parallel_out), 64'(m_sr));
    chk({tag, ".bit_count"},    64'(bus.bit_count),    64'(m_cnt));
    chk({tag, ".word_valid"},   64'(bus.word_valid),   64'(exp_q.size() != 0));
    chk({tag, ".word_out"},     64'(bus.word_out),     64'(m_word));
    chk({tag, ".overrun"},      64'(bus.overrun),      64'(m_overrun));
    chk({tag, ".serial_out"},   64'(bus.serial_out),   64'(sout));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic ld, input logic sh, input logic msb,
                      input logic sin, input logic [7:0] ldata, input logic rdy);
    bus.load_enable  = ld;
    bus.shift_enable = sh;
    bus.msb_first    = msb;
    bus.serial_in    = sin;
    bus.load_data    = ldata;
    bus.word_ready   = rdy;
    @(posedge clk);
    model_step(ld, sh, msb, sin, ldata, rdy);
    #1;
    bus.load_enable  = 1'b0;
    bus.shift_enable = 1'b0;
    bus.word_ready   = 1'b0;
    check_all(tag);
  endtask

  task automatic shift_word(input string tag, input logic msb, input logic [7:0] bits,
                            input logic rdy_last);
    // bits[7] goes in first
    for (int i = 7; i >= 0; i--)
      step(tag, 1'b0, 1'b1, msb, bits[i], 8'h00, (i == 0) ? rdy_last : 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    bus.shift_enable = 1'b0;
    bus.msb_first    = 1'b1;
    bus.serial_in    = 1'b0;
    bus.load_enable  = 1'b0;
    bus.load_data    = 8'h00;
    bus.word_ready   = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held");
    chk("reset_parallel_ff", 64'(bus.parallel_out), 64'h00FF);
    rst = 1'b0;

    // MSB-first 1,0,1,0,0,1,0,1
    shift_word("msb_a5", 1'b1, 8'b1010_0101, 1'b0);
    chk("msb_a5_word", 64'(bus.word_out), 64'hA5);
    step("consume_a5", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // LSB-first, same order, then 1,1,1,1,0,0,0,0
    shift_word("lsb_a5", 1'b0, 8'b1010_0101, 1'b0);
    chk("lsb_a5_word", 64'(bus.word_out), 64'hA5);
    step("consume_lsb", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    shift_word("lsb_0f", 1'b0, 8'b1111_0000, 1'b0);
    chk("lsb_0f_word", 64'(bus.word_out), 64'h0F);
    step("consume_0f", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Load beats shift
    step("pre_load", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    step("load_3c", 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0);
    chk("load_serial_out", 64'(bus.serial_out), 64'h0);
    chk("load_bit_count", 64'(bus.bit_count), 64'h0);
    step("idle_hold", 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);

    // Direction change mid-word keeps count and contents
    step("dir_a", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    step("dir_flip", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step("dir_b", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    step("reload", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Overrun: two words, no ready
    shift_word("ovr_w1", 1'b1, 8'h5A, 1'b0);
    shift_word("ovr_w2", 1'b1, 8'hC3, 1'b0);
    chk("ovr_kept_first", 64'(bus.word_out), 64'h5A);
    chk("ovr_flag", 64'(bus.overrun), 64'h1);
    step("ovr_consume", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("ovr_valid_clear", 64'(bus.word_valid), 64'h0);
    chk("ovr_sticky", 64'(bus.overrun), 64'h1);

    // Async reset mid-word with a word held
    shift_word("pre_rst_w", 1'b1, 8'h11, 1'b0);
    step("mid_a", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    step("mid_b", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    async_reset("rst_mid");

    // Capture coincident with ready while a word is held
    shift_word("coin_w1", 1'b1, 8'h96, 1'b0);
    shift_word("coin_w2", 1'b1, 8'h4B, 1'b1);
    chk("coin_word", 64'(bus.word_out), 64'h4B);
    chk("coin_valid", 64'(bus.word_valid), 64'h1);
    chk("coin_overrun", 64'(bus.overrun), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic ld, sh, msb, sin, rdy;
      logic [7:0] d;
      ld  = ($urandom_range(0, 19) == 0);
      sh  = ($urandom_range(0, 9) < 7);
      msb = ($urandom_range(0, 9) < 6);
      sin = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 9) < 3);
      d   = 8'($urandom_range(0, 255));
      step("rand", ld, sh, msb, sin, d, rdy);
      if (i == 200) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/flex_word_sr.md
FLEX_WORD_SR -- requirements
Module: flex_word_sr

Interface
REQ-001 The module SHALL have parameter NUM_BITS, default 8, meaning shift register and word width; legal range 2..64.
REQ-002 The module SHALL have parameter RESET_BIT, default 1, meaning the value loaded into every shift-register bit at reset (idle-line level).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 The module SHALL have port shift_enable  input  1  meaning shift one bit this cycle.
REQ-006 The module SHALL have port msb_first  input  1  meaning runtime direction: 1 shifts toward MSB, 0 toward LSB.
REQ-007 The module SHALL have port serial_in  input  1  meaning serial data in.
REQ-008 The module SHALL have port load_enable  input  1  meaning parallel load of load_data this cycle.
REQ-009 The module SHALL have port load_data  input  NUM_BITS  meaning parallel load value.
REQ-010 The module SHALL have port serial_out  output  1  meaning bit currently leaving the register.
REQ-011 The module SHALL have port parallel_out  output  NUM_BITS  meaning live shift-register contents.
REQ-012 The module SHALL have port word_out  output  NUM_BITS  meaning captured complete word (holding register).
REQ-013 The module SHALL have port word_valid  output  1  meaning word_out holds an unconsumed word.
REQ-014 The module SHALL have port word_ready  input  1  meaning consumer accepts word_out this cycle.
REQ-015 The module SHALL have port overrun  output  1  meaning sticky flag: a completed word was dropped.
REQ-016 The module SHALL have port bit_count  output  $clog2(NUM_BITS)  meaning bits shifted into the current word.

Function
REQ-017 load_enable SHALL take priority over shift_enable: parallel_out <= load_data, bit_count <= 0, no word capture.
REQ-018 Shift with msb_first=1 SHALL give parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in}; with msb_first=0, {serial_in, parallel_out[NUM_BITS-1:1]}.
REQ-019 Neither enable asserted SHALL hold parallel_out and bit_count.
REQ-020 serial_out SHALL be combinational: parallel_out[NUM_BITS-1] when msb_first=1, else parallel_out[0].
REQ-021 Each shift SHALL increment bit_count; the shift with bit_count==NUM_BITS-1 SHALL wrap bit_count to 0 and raise a capture event carrying the post-shift register value.
REQ-022 A capture with word_valid=0, or with word_valid=1 and word_ready=1 in the same cycle, SHALL load word_out with the new word and set word_valid=1 the next cycle.
REQ-023 A capture with word_valid=1 and word_ready=0 SHALL keep word_out unchanged, drop the new word, and set overrun=1.
REQ-024 word_valid=1 and word_ready=1 with no capture SHALL clear word_valid next cycle; word_out holds its value.
REQ-025 word_ready while word_valid=0 SHALL have no effect.
REQ-026 overrun SHALL remain 1 until reset.
REQ-027 A msb_first change mid-word SHALL take effect on the next shift and SHALL NOT alter bit_count or register contents.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk: parallel_out={NUM_BITS{RESET_BIT}}, word_out=0, word_valid=0, overrun=0, bit_count=0.
REQ-029 Reset mid-word or with word_valid=1 SHALL discard all partial and held data; the first post-reset shift is bit 1 of a new word.

Verification (NUM_BITS=8, RESET_BIT=1)
REQ-030 Reset -> parallel_out=0xFF, word_out=0x00, word_valid=0, overrun=0, bit_count=0.
REQ-031 msb_first=1, shift in 1,0,1,0,0,1,0,1 over 8 cycles -> word_out=0xA5, word_valid=1 the cycle after the 8th shift, bit_count=0.
REQ-032 msb_first=0, same bit order -> word_out=0xA5 reversed = 0xA5 bitwise-reversed (0xA5), then repeat with 1,1,1,1,0,0,0,0 -> word_out=0x0F.
REQ-033 load_data=0x3C with load_enable and shift_enable both high -> parallel_out=0x3C, bit_count=0, serial_out=0 (msb_first=1).
REQ-034 Two complete words with word_ready=0 -> first word retained in word_out, overrun=1; then word_ready=1 one cycle -> word_valid=0, overrun still 1.
REQ-035 8th shift coincident with word_ready=1 and word_valid=1 -> word_out updates to new word, word_valid stays 1, overrun=0.
